splitter_n: RTL and testbench

Registered 1-to-N demultiplexer with a valid/ready handshake. It is the parametrised successor to the 2-way D/I splitter. Each input beat is steered by `selector` into one of CHANNELS single-entry output registers. Each register drains independently to its consumer. Channels with no valid beat drive IDLE_VALUE, the same all-ones idle convention as the 2-way splitter. Sits between the fetch/load path and the memory-side consumers, e.g. instruction, data and I/O ports.

---
 rtl/splitter_n.sv | 119 +++++++++++
 tb/tb_splitter_n.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/splitter_n.sv
// splitter_n: registered 1-to-N demultiplexer with a valid/ready handshake.
// Each accepted beat is steered by `selector` into one of CHANNELS
// single-entry output registers, and each register drains independently.
// Channels holding no beat drive IDLE_VALUE.
// Optional feature macro: SPLITTER_DROP_CNT_EN adds a saturating 16-bit
// `drop_count` output that counts beats dropped for an out-of-range selector.
module splitter_n #(
    parameter int                   BIT_WIDTH  = 8,
    parameter int                   CHANNELS   = 4,
    parameter int                   SEL_WIDTH  = 2,
    parameter logic [BIT_WIDTH-1:0] IDLE_VALUE = {BIT_WIDTH{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BIT_WIDTH-1:0]          in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_WIDTH-1:0]          selector,
    input  logic                          enable,
    output logic [CHANNELS*BIT_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]           out_valid,
    input  logic [CHANNELS-1:0]           out_ready,
`ifdef SPLITTER_DROP_CNT_EN
    output logic [15:0]                   drop_count,
`endif
    output logic                          sel_err
);

    logic [BIT_WIDTH-1:0] data_q [CHANNELS];
    logic [BIT_WIDTH-1:0] data_d [CHANNELS];
    logic [CHANNELS-1:0]  valid_q;
    logic [CHANNELS-1:0]  valid_d;
    logic                 sel_err_q;
    logic                 sel_err_d;

    logic                 selInRange;
    logic                 selFree;
    logic [CHANNELS-1:0]  chanFree;
    logic [CHANNELS-1:0]  loadVec;
    logic                 accept;

    // A channel is free when empty or draining this cycle, so a full channel
    // can be refilled back-to-back; out-of-range beats are always taken and dropped.
    always_comb begin
        chanFree   = ~valid_q | out_ready;
        selInRange = (int'(selector) < CHANNELS);
        selFree    = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(selector) == k) begin
                selFree = chanFree[k];
            end
        end
        in_ready = enable && (selInRange ? selFree : 1'b1);
        accept   = in_valid && in_ready;
    end

    // Next state per channel: a load beats a drain, a stalled beat holds,
    // and a drained or empty channel returns to the idle value.
    always_comb begin
        loadVec   = '0;
        valid_d   = '0;
        sel_err_d = accept && !selInRange;
        for (int k = 0; k < CHANNELS; k++) begin
            loadVec[k] = accept && selInRange && (int'(selector) == k);
            valid_d[k] = loadVec[k] || (valid_q[k] && !out_ready[k]);
            if (loadVec[k]) begin
                data_d[k] = in;
            end else if (valid_q[k] && !out_ready[k]) begin
                data_d[k] = data_q[k];
            end else begin
                data_d[k] = IDLE_VALUE;
            end
        end
    end

    // Channel registers and the one-cycle selector error pulse; reset drops every held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            sel_err_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                data_q[k] <= IDLE_VALUE;
            end
        end else begin
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
            for (int k = 0; k < CHANNELS; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Pack the channel registers onto the flat output bus.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            out_data[k*BIT_WIDTH +: BIT_WIDTH] = data_q[k];
        end
    end

    assign out_valid = valid_q;
    assign sel_err   = sel_err_q;

`ifdef SPLITTER_DROP_CNT_EN
    logic [15:0] drop_count_q;

    // Count dropped out-of-range beats, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= 16'h0000;
        end else if (sel_err_d && (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'h0001;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_splitter_n.sv
// tb_splitter_n: scoreboard bench for splitter_n. A four-channel instance
// carries routing, backpressure, enable and reset traffic; a three-channel
// instance exercises the out-of-range selector path.
module tb_splitter_n;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [7:0]  din;
    logic        inValid;
    logic        inReady;
    logic [1:0]  sel;
    logic        enable;
    logic [31:0] outData;
    logic [3:0]  outValid;
    logic [3:0]  outReady;
    logic        selErr;

    logic [7:0]  din3;
    logic        inValid3;
    logic        inReady3;
    logic [1:0]  sel3;
    logic        enable3;
    logic [23:0] outData3;
    logic [2:0]  outValid3;
    logic [2:0]  outReady3;
    logic        selErr3;

`ifdef SPLITTER_DROP_CNT_EN
    logic [15:0] dropCount;
    logic [15:0] dropCount3;
`endif

    int   checks;
    int   errors;
    int   cycle;
    exp_t expQ [4][$];

    splitter_n #(.BIT_WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .selector  (sel),
        .enable    (enable),
        .out_data  (outData),
        .out_valid (outValid),
        .out_ready (outReady),
`ifdef SPLITTER_DROP_CNT_EN
        .drop_count(dropCount),
`endif
        .sel_err   (selErr)
    );

    splitter_n #(.BIT_WIDTH(8), .CHANNELS(3), .SEL_WIDTH(2)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din3),
        .in_valid  (inValid3),
        .in_ready  (inReady3),
        .selector  (sel3),
        .enable    (enable3),
        .out_data  (outData3),
        .out_valid (outValid3),
        .out_ready (outReady3),
`ifdef SPLITTER_DROP_CNT_EN
        .drop_count(dropCount3),
`endif
        .sel_err   (selErr3)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time out expected beats that never appear.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
                     name, actual, expected, cycle);
        end
    endtask

    // Drive one beat after the rising edge, check in_ready mid-cycle and
    // record the expected output beat when it should be accepted.
    task automatic applyStimulus(input logic v, input logic [1:0] s,
                                 input logic [7:0] d, input logic expReady);
        exp_t e;
        inValid = v;
        sel     = s;
        din     = d;
        @(negedge clk);
        checkOutput("in_ready", {31'd0, inReady}, {31'd0, expReady});
        if (v && expReady) begin
            e.data = d;
            e.due  = cycle + 1;
            expQ[s].push_back(e);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every mid-cycle, compare each channel against the scoreboard,
    // popping a beat whenever the consumer takes it.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (outValid[k]) begin
                if (expQ[k].size() == 0) begin
                    checkOutput($sformatf("ch%0d_unexpected_valid", k), 32'd1, 32'd0);
                end else begin
                    checkOutput($sformatf("ch%0d_data", k),
                                {24'd0, outData[k*8 +: 8]}, {24'd0, expQ[k][0].data});
                    if (outReady[k]) begin
                        void'(expQ[k].pop_front());
                    end
                end
            end else begin
                checkOutput($sformatf("ch%0d_idle_data", k),
                            {24'd0, outData[k*8 +: 8]}, 32'h0000_00FF);
                if (expQ[k].size() != 0 && cycle >= expQ[k][0].due) begin
                    checkOutput($sformatf("ch%0d_latency", k), 32'd0, 32'd1);
                    void'(expQ[k].pop_front());
                end
            end
        end
    end

    initial begin
        cycle     = 0;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        din       = 8'h00;
        inValid   = 1'b0;
        sel       = 2'd0;
        enable    = 1'b1;
        outReady  = 4'hF;
        din3      = 8'h00;
        inValid3  = 1'b0;
        sel3      = 2'd0;
        enable3   = 1'b1;
        outReady3 = 3'b111;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", {28'd0, outValid}, 32'd0);
        checkOutput("reset_out_data", outData, 32'hFFFF_FFFF);
        checkOutput("reset_sel_err", {31'd0, selErr}, 32'd0);
        checkOutput("reset3_out_data", {8'd0, outData3}, 32'h00FF_FFFF);
`ifdef SPLITTER_DROP_CNT_EN
        checkOutput("reset_drop_count", {16'd0, dropCount3}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(2);

        // Basic routing, one beat to each channel back-to-back
        applyStimulus(1'b1, 2'd0, 8'h11, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'h22, 1'b1);
        applyStimulus(1'b1, 2'd2, 8'h33, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'h44, 1'b1);
        @(negedge clk);
        checkOutput("route_ch3_valid", {28'd0, outValid}, 32'h8);
        checkOutput("route_sel_err", {31'd0, selErr}, 32'd0);
        idleCycles(3);

        // Backpressure on channel 1, other channels keep flowing
        outReady = 4'b1101;
        applyStimulus(1'b1, 2'd1, 8'hA1, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'hA2, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'hB0, 1'b1);
        idleCycles(2);
        outReady = 4'hF;
        applyStimulus(1'b1, 2'd1, 8'hA2, 1'b1);
        @(negedge clk);
        checkOutput("refill_ch1_valid", {31'd0, outValid[1]}, 32'd1);
        checkOutput("refill_ch1_data", {24'd0, outData[15:8]}, 32'h0000_00A2);
        idleCycles(2);

        // Enable gating: nothing loads, held beat still drains
        outReady = 4'b1110;
        applyStimulus(1'b1, 2'd0, 8'hC0, 1'b1);
        enable = 1'b0;
        applyStimulus(1'b1, 2'd2, 8'hD0, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'hD1, 1'b0);
        outReady = 4'hF;
        idleCycles(1);
        @(negedge clk);
        checkOutput("gated_ch0_idle", {24'd0, outData[7:0]}, 32'h0000_00FF);
        checkOutput("gated_out_valid", {28'd0, outValid}, 32'd0);
        enable = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-operation clears a stalled beat without a clock edge
        outReady = 4'b1011;
        applyStimulus(1'b1, 2'd2, 8'h5A, 1'b1);
        @(negedge clk);
        checkOutput("held_ch2_valid", {31'd0, outValid[2]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", {28'd0, outValid}, 32'd0);
        checkOutput("async_reset_data", outData, 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) expQ[k].delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        outReady = 4'hF;
        idleCycles(1);

        // Out-of-range selector on the three-channel instance
        sel3     = 2'd3;
        din3     = 8'h77;
        inValid3 = 1'b1;
        @(negedge clk);
        checkOutput("oor_in_ready", {31'd0, inReady3}, 32'd1);
        checkOutput("oor_sel_err_before", {31'd0, selErr3}, 32'd0);
        @(posedge clk);
        #1;
        inValid3 = 1'b0;
        @(negedge clk);
        checkOutput("oor_sel_err_pulse", {31'd0, selErr3}, 32'd1);
        checkOutput("oor_out_valid", {29'd0, outValid3}, 32'd0);
`ifdef SPLITTER_DROP_CNT_EN
        checkOutput("drop_count_one", {16'd0, dropCount3}, 32'd1);
`endif
        @(negedge clk);
        checkOutput("oor_sel_err_clear", {31'd0, selErr3}, 32'd0);

        // Out-of-range with enable low: not accepted, no error
        enable3  = 1'b0;
        inValid3 = 1'b1;
        @(negedge clk);
        checkOutput("oor_gated_ready", {31'd0, inReady3}, 32'd0);
        @(posedge clk);
        #1;
        inValid3 = 1'b0;
        enable3  = 1'b1;
        @(negedge clk);
        checkOutput("oor_gated_sel_err", {31'd0, selErr3}, 32'd0);

`ifdef SPLITTER_DROP_CNT_EN
        // Saturation: 65536 more drops on top of the first
        @(posedge clk);
        #1;
        inValid3 = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        inValid3 = 1'b0;
        @(negedge clk);
        checkOutput("drop_count_saturate", {16'd0, dropCount3}, 32'h0000_FFFF);
`endif

        idleCycles(2);
        checkOutput("scoreboard_empty",
                    expQ[0].size() + expQ[1].size() + expQ[2].size() + expQ[3].size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
